// File: rtl/seg_scan_decoder_if.sv
// Scanned 7-segment display bus plus the decoded view produced by seg_scan_decoder.
// master: the side that drives the display bus and observes the decode results.
// slave : the decoder itself.
interface seg_scan_decoder_if;
    logic [3:0]  anode;        // active-low digit enables, bit 0 = rightmost digit
    logic [7:0]  segment;      // active-low {dp,g,f,e,d,c,b,a}
    logic [15:0] digits;       // decoded nibbles, digits[4i+3:4i] = digit i
    logic [3:0]  dp;           // decoded decimal points, active-high
    logic [3:0]  digit_valid;  // last capture of digit i was a legal hex glyph
    logic        frame_done;   // one-cycle pulse per completed four-digit frame
    logic        bad_code;     // sticky: illegal glyph or multi-hot anode seen

    modport master (
        output anode,
        output segment,
        input  digits,
        input  dp,
        input  digit_valid,
        input  frame_done,
        input  bad_code
    );

    modport slave (
        input  anode,
        input  segment,
        output digits,
        output dp,
        output digit_valid,
        output frame_done,
        output bad_code
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Receive side of a 4-digit multiplexed 7-segment display. Registers the scanned bus, waits
// for each slot to be stable for STABLE_CYCLES samples, then decodes it once into a hex nibble
// and decimal point. Flags illegal glyphs and multi-hot anodes, and pulses once per full frame.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_decoder_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    // Idle bus (all anodes and segments off); keeps the first post-reset sample from
    // looking like an all-digits-on multi-hot anode.
    localparam logic [11:0]      BusIdle = 12'hFFF;

    logic [11:0]      r_smp;
    logic [11:0]      r_prev;
    logic [CNT_W-1:0] r_cnt;
    state_e           r_state;
    logic [15:0]      r_digits;
    logic [3:0]       r_dp;
    logic [3:0]       r_valid;
    logic [3:0]       r_seen;
    logic             r_frame_done;
    logic             r_bad_code;

    logic       w_eq;
    logic       w_reach;
    logic [3:0] w_anode;
    logic [3:0] w_low;
    logic [7:0] w_seg;
    logic [6:0] w_glyph;
    logic       w_blank_anode;
    logic       w_onehot;
    logic       w_multi;
    logic [1:0] w_slot;
    logic [3:0] w_slot_bit;
    logic       w_hex_ok;
    logic [3:0] w_hex;
    logic       w_glyph_off;
    logic [3:0] w_seen_base;

    // Input stage: two-deep sample pipeline used for the stability compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp  <= BusIdle;
            r_prev <= BusIdle;
        end else begin
            r_smp  <= {bus.anode, bus.segment};
            r_prev <= r_smp;
        end
    end

    assign w_eq          = (r_smp == r_prev);
    assign w_anode       = r_smp[11:8];
    assign w_seg         = r_smp[7:0];
    assign w_low         = ~w_anode;
    assign w_glyph       = ~w_seg[6:0];
    assign w_blank_anode = (w_anode == 4'b1111);
    assign w_onehot      = $onehot(w_low);
    assign w_multi       = (w_low != 4'b0000) && !w_onehot;
    assign w_glyph_off   = (w_glyph == 7'h00);
    // Capture fires on the edge where the counter would step into STABLE_CYCLES.
    assign w_reach       = w_eq && (r_cnt == CntLast);
    assign w_slot_bit    = 4'b0001 << w_slot;
    // A full mask is cleared on the cycle after it fills; a capture then lands in the empty mask.
    assign w_seen_base   = (r_seen == 4'b1111) ? 4'b0000 : r_seen;

    // Stability counter: restarts on any change, saturates at STABLE_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_eq) begin
            r_cnt <= '0;
        end else if (r_cnt != CntMax) begin
            r_cnt <= r_cnt + CntOne;
        end
    end

    // Slot index of the single active anode (only meaningful when w_onehot).
    always_comb begin
        w_slot = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_low[i]) begin
                w_slot = 2'(i);
            end
        end
    end

    // Hex glyph lookup on the active-high gfedcba pattern.
    always_comb begin
        w_hex_ok = 1'b1;
        w_hex    = 4'h0;
        case (w_glyph)
            7'h3F: w_hex = 4'h0;
            7'h06: w_hex = 4'h1;
            7'h5B: w_hex = 4'h2;
            7'h4F: w_hex = 4'h3;
            7'h66: w_hex = 4'h4;
            7'h6D: w_hex = 4'h5;
            7'h7D: w_hex = 4'h6;
            7'h07: w_hex = 4'h7;
            7'h7F: w_hex = 4'h8;
            7'h6F: w_hex = 4'h9;
            7'h77: w_hex = 4'hA;
            7'h7C: w_hex = 4'hB;
            7'h39: w_hex = 4'hC;
            7'h5E: w_hex = 4'hD;
            7'h79: w_hex = 4'hE;
            7'h71: w_hex = 4'hF;
            default: w_hex_ok = 1'b0;
        endcase
    end

    // Scan FSM with capture actions and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_digits     <= '0;
            r_dp         <= '0;
            r_valid      <= '0;
            r_seen       <= '0;
            r_frame_done <= 1'b0;
            r_bad_code   <= 1'b0;
        end else begin
            r_frame_done <= (r_seen == 4'b1111);
            r_seen       <= w_seen_base;
            unique case (r_state)
                StIdle: begin
                    if (!w_blank_anode) begin
                        r_state <= StSettle;
                    end
                end
                StSettle: begin
                    if (w_reach) begin
                        r_state <= StHold;
                        if (w_onehot) begin
                            r_seen <= w_seen_base | w_slot_bit;
                            if (w_hex_ok) begin
                                r_digits[{w_slot, 2'b00} +: 4] <= w_hex;
                                r_dp[w_slot]                   <= ~w_seg[7];
                                r_valid[w_slot]                <= 1'b1;
                            end else begin
                                r_valid[w_slot] <= 1'b0;
                                if (!w_glyph_off) begin
                                    r_bad_code <= 1'b1;
                                end
                            end
                        end else if (w_multi) begin
                            r_bad_code <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (!w_eq) begin
                        r_state <= w_blank_anode ? StIdle : StSettle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.digits      = r_digits;
    assign bus.dp          = r_dp;
    assign bus.digit_valid = r_valid;
    assign bus.frame_done  = r_frame_done;
    assign bus.bad_code    = r_bad_code;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: a run-length behavioural model checked every cycle,
// plus hand-computed literal checks for reset, latency, frame pulse and error cases.
module tb_seg_scan_decoder;
    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(
        .STABLE_CYCLES(STABLE),
        .CNT_W        (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;

    logic [6:0] hex_glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: a value held on the bus for STABLE+2 consecutive edges is captured once.
    logic [11:0] m_last   = 12'hFFF;
    int          m_run    = 0;
    logic [15:0] m_digits = '0;
    logic [3:0]  m_dp     = '0;
    logic [3:0]  m_valid  = '0;
    logic [3:0]  m_seen   = '0;
    logic        m_pend   = 1'b0;
    logic        m_frame  = 1'b0;
    logic        m_bad    = 1'b0;
    logic [11:0] m_v;
    logic [3:0]  m_lows;
    logic [6:0]  m_g;
    int          m_slot;
    int          m_nib;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last = 12'hFFF; m_run = 0; m_digits = '0; m_dp = '0; m_valid = '0;
            m_seen = '0; m_pend = 1'b0; m_frame = 1'b0; m_bad = 1'b0;
        end else begin
            m_v = {bus.anode, bus.segment};
            if (m_v != m_last) m_run = 1;
            else if (m_run < 1000) m_run++;
            m_last  = m_v;
            m_frame = m_pend;
            if (m_pend) begin
                m_seen = '0;
                m_pend = 1'b0;
            end
            if (m_run == STABLE + 2) begin
                m_lows = ~m_v[11:8];
                m_g    = ~m_v[6:0];
                if ($countones(m_lows) == 1) begin
                    m_slot = 0;
                    for (int i = 0; i < 4; i++) if (m_lows[i]) m_slot = i;
                    m_nib = -1;
                    for (int k = 0; k < 16; k++) if (hex_glyph[k] == m_g) m_nib = k;
                    if (m_nib >= 0) begin
                        m_digits[m_slot*4 +: 4] = 4'(m_nib);
                        m_dp[m_slot]            = ~m_v[7];
                        m_valid[m_slot]         = 1'b1;
                    end else begin
                        m_valid[m_slot] = 1'b0;
                        if (m_g != 7'h00) m_bad = 1'b1;
                    end
                    m_seen[m_slot] = 1'b1;
                    if (m_seen == 4'hF) m_pend = 1'b1;
                end else if ($countones(m_lows) >= 2) begin
                    m_bad = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        n_checks++;
        if ({bus.digits, bus.dp, bus.digit_valid, bus.frame_done, bus.bad_code} !==
            {m_digits, m_dp, m_valid, m_frame, m_bad}) begin
            n_errors++;
            $display("FAIL model_cmp t=%0t got digits=%h dp=%b valid=%b frame=%b bad=%b, required digits=%h dp=%b valid=%b frame=%b bad=%b",
                     $time, bus.digits, bus.dp, bus.digit_valid, bus.frame_done, bus.bad_code,
                     m_digits, m_dp, m_valid, m_frame, m_bad);
        end
        if (bus.frame_done === 1'b1) n_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_digits"}, 32'(bus.digits), 32'h0);
        check({name, "_dp"}, 32'(bus.dp), 32'h0);
        check({name, "_valid"}, 32'(bus.digit_valid), 32'h0);
        check({name, "_frame"}, 32'(bus.frame_done), 32'h0);
        check({name, "_bad"}, 32'(bus.bad_code), 32'h0);
    endtask

    // Apply a bus value at a falling edge and hold it for n clock periods.
    task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
        bus.anode   = a;
        bus.segment = s;
        repeat (n) @(negedge clk);
    endtask

    int p0;

    initial begin
        bus.anode   = 4'b0101;
        bus.segment = 8'h12;

        // T1: reset with junk inputs, then an idle bus
        repeat (3) @(negedge clk);
        check_zero("t1_in_reset");
        rst = 1'b0;
        drive(4'b1111, 8'hFF, 20);
        check_zero("t1_idle");

        // T2: too-short hold, then a long hold with exact latency
        drive(4'b1110, 8'hF9, 3);
        drive(4'b1111, 8'hFF, 8);
        check("t2_short_valid", 32'(bus.digit_valid), 32'h0);
        check("t2_short_digits", 32'(bus.digits), 32'h0);
        drive(4'b1110, 8'hF9, 5);
        check("t2_before_edge5", 32'(bus.digit_valid), 32'h0);
        @(negedge clk);
        check("t2_edge5_digit", 32'(bus.digits[3:0]), 32'h1);
        check("t2_edge5_valid", 32'(bus.digit_valid), 32'b0001);
        repeat (4) @(negedge clk);
        drive(4'b1111, 8'hFF, 4);
        check("t2_no_frame", 32'(n_pulses), 32'h0);

        // T3: full frame scan
        p0 = n_pulses;
        drive(4'b1110, 8'hF9, 8);
        drive(4'b1101, 8'hA4, 8);
        drive(4'b1011, 8'h30, 8);
        drive(4'b0111, 8'h99, 6);
        check("t3_slot3_captured", 32'(bus.digit_valid), 32'hF);
        check("t3_frame_not_yet", 32'(bus.frame_done), 32'h0);
        @(negedge clk);
        check("t3_frame_pulse", 32'(bus.frame_done), 32'h1);
        @(negedge clk);
        check("t3_frame_end", 32'(bus.frame_done), 32'h0);
        drive(4'b1111, 8'hFF, 4);
        check("t3_digits", 32'(bus.digits), 32'h4321);
        check("t3_dp", 32'(bus.dp), 32'b0100);
        check("t3_valid", 32'(bus.digit_valid), 32'hF);
        check("t3_bad", 32'(bus.bad_code), 32'h0);
        check("t3_pulse_count", 32'(n_pulses - p0), 32'h1);

        // T4: illegal glyph, then blank on the same slot
        drive(4'b1110, 8'hAA, 8);
        check("t4_bad", 32'(bus.bad_code), 32'h1);
        check("t4_valid", 32'(bus.digit_valid), 32'b1110);
        check("t4_digits", 32'(bus.digits), 32'h4321);
        drive(4'b1110, 8'hFF, 8);
        check("t4_blank_bad", 32'(bus.bad_code), 32'h1);
        check("t4_blank_valid", 32'(bus.digit_valid), 32'b1110);
        drive(4'b1111, 8'hFF, 4);

        // T5: multi-hot anode
        drive(4'b1100, 8'hC0, 8);
        check("t5_bad", 32'(bus.bad_code), 32'h1);
        check("t5_digits", 32'(bus.digits), 32'h4321);
        check("t5_valid", 32'(bus.digit_valid), 32'b1110);
        drive(4'b1111, 8'hFF, 4);

        // T6: asynchronous reset in the middle of a settling slot
        bus.anode   = 4'b0111;
        bus.segment = 8'h88;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("t6_async_rst");
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("t6_after_rst");
        repeat (10) @(negedge clk);
        check("t6_digits", 32'(bus.digits), 32'hA000);
        check("t6_valid", 32'(bus.digit_valid), 32'b1000);
        check("t6_bad", 32'(bus.bad_code), 32'h0);

        drive(4'b1111, 8'hFF, 4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
